// File: rtl/rnn_pkg.sv
// Shared register map and FSM state encoding for the RNN accelerator driver.
package rnn_pkg;

  localparam logic [2:0] REG_START  = 3'd0;
  localparam logic [2:0] REG_INPUT  = 3'd1;
  localparam logic [2:0] REG_R0     = 3'd2;
  localparam logic [2:0] REG_R1     = 3'd3;
  localparam logic [2:0] REG_RB     = 3'd4;
  localparam logic [2:0] REG_DENSE  = 3'd5;
  localparam logic [2:0] REG_DBIAS  = 3'd6;
  localparam logic [2:0] REG_RESULT = 3'd7;

  typedef logic [3:0] drv_state_t;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_P_RD    = 4'd1;
  localparam logic [3:0] S_P_WR    = 4'd2;
  localparam logic [3:0] S_CH_WAIT = 4'd3;
  localparam logic [3:0] S_CH_W0   = 4'd4;
  localparam logic [3:0] S_CH_W1   = 4'd5;
  localparam logic [3:0] S_CH_GO   = 4'd6;
  localparam logic [3:0] S_CH_POLL = 4'd7;
  localparam logic [3:0] S_D_GO    = 4'd8;
  localparam logic [3:0] S_D_POLL  = 4'd9;
  localparam logic [3:0] S_D_RD    = 4'd10;
  localparam logic [3:0] S_RES     = 4'd11;

endpackage

// File: rtl/rnn_driver_if.sv
// Character stream, result stream and accelerator register port of the driver.
interface rnn_driver_if;
  logic        ch_valid;
  logic        ch_ready;
  logic        ch_last;
  logic [31:0] ch_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_pos;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_addr;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    input  ch_valid, ch_last, ch_data, res_ready, m_readdata,
    output ch_ready, res_valid, res_data, res_pos, m_read, m_write, m_addr, m_writedata
  );

  modport slave (
    output ch_valid, ch_last, ch_data, res_ready, m_readdata,
    input  ch_ready, res_valid, res_data, res_pos, m_read, m_write, m_addr, m_writedata
  );
endinterface

// File: rtl/rnn_driver_poll_timer.sv
// Counts consecutive poll cycles; expired_o flags the cycle where TIMEOUT polls are used up.
module poll_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT));
endmodule

// File: rtl/rnn_driver.sv
// Sequences parameter ROM loads, character injection, polling and result readout for the RNN accelerator.
module rnn_driver
  import rnn_pkg::*;
#(
  parameter int PARAM_WORDS = 1217,
  parameter int ROM_AW      = 11,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  output logic              busy,
  output logic              err,
  output logic [ROM_AW-1:0] p_addr,
  input  logic [34:0]       p_data,
  rnn_driver_if.master      bus
);
  drv_state_t        state_q, state_d;
  logic [ROM_AW-1:0] index_q, index_d;
  logic [31:0]       emb_q, emb_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [15:0]       res_q, res_d;
  logic              pos_q, pos_d;

  logic              poll_en_s, expired_s;
  logic              m_read_s, m_write_s, ch_ready_s, res_valid_s;
  logic [2:0]        m_addr_s;
  logic [31:0]       m_wdata_s;
  logic              unused_rdata_s;

  assign poll_en_s = (state_q == S_CH_POLL) || (state_q == S_D_POLL);

  poll_timer #(.TIMEOUT(TIMEOUT)) u_poll_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (poll_en_s),
    .expired_o (expired_s)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    emb_d       = emb_q;
    last_d      = last_q;
    err_d       = err_q;
    res_d       = res_q;
    pos_d       = pos_q;
    m_read_s    = 1'b0;
    m_write_s   = 1'b0;
    m_addr_s    = 3'd0;
    m_wdata_s   = 32'h0000_0000;
    ch_ready_s  = 1'b0;
    res_valid_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_P_RD;
          index_d = '0;
          err_d   = 1'b0;
        end else if (bus.ch_valid) begin
          state_d = S_CH_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P_RD: state_d = S_P_WR;
      S_P_WR: begin
        m_write_s = 1'b1;
        m_addr_s  = p_data[34:32];
        m_wdata_s = p_data[31:0];
        if (index_q == ROM_AW'(PARAM_WORDS - 1)) begin
          index_d = '0;
          state_d = S_IDLE;
        end else begin
          index_d = index_q + {{(ROM_AW-1){1'b0}}, 1'b1};
          state_d = S_P_RD;
        end
      end
      S_CH_WAIT: begin
        ch_ready_s = 1'b1;
        if (bus.ch_valid) begin
          emb_d   = bus.ch_data;
          last_d  = bus.ch_last;
          err_d   = 1'b0;
          state_d = S_CH_W0;
        end else begin
          state_d = S_CH_WAIT;
        end
      end
      S_CH_W0: begin
        m_write_s = 1'b1;
        m_addr_s  = REG_INPUT;
        m_wdata_s = {8'h00, 8'h00, emb_q[15:0]};
        state_d   = S_CH_W1;
      end
      S_CH_W1: begin
        m_write_s = 1'b1;
        m_addr_s  = REG_INPUT;
        m_wdata_s = {8'h00, 8'h01, emb_q[31:16]};
        state_d   = S_CH_GO;
      end
      S_CH_GO: begin
        m_write_s = 1'b1;
        m_addr_s  = REG_START;
        state_d   = S_CH_POLL;
      end
      // On expiry the bus stays idle: no read is issued in the give-up cycle.
      S_CH_POLL: begin
        if (expired_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          m_read_s = 1'b1;
          m_addr_s = REG_INPUT;
          if (bus.m_readdata[0]) begin
            state_d = last_q ? S_D_GO : S_IDLE;
          end else begin
            state_d = S_CH_POLL;
          end
        end
      end
      S_D_GO: begin
        m_write_s = 1'b1;
        m_addr_s  = REG_RESULT;
        state_d   = S_D_POLL;
      end
      S_D_POLL: begin
        if (expired_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          m_read_s = 1'b1;
          m_addr_s = REG_START;
          state_d  = bus.m_readdata[0] ? S_D_RD : S_D_POLL;
        end
      end
      S_D_RD: begin
        m_read_s = 1'b1;
        m_addr_s = REG_RESULT;
        res_d    = bus.m_readdata[15:0];
        pos_d    = ~bus.m_readdata[15];
        state_d  = S_RES;
      end
      S_RES: begin
        res_valid_s = 1'b1;
        state_d     = bus.res_ready ? S_IDLE : S_RES;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      emb_q   <= 32'h0000_0000;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= 16'h0000;
      pos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      emb_q   <= emb_d;
      last_q  <= last_d;
      err_q   <= err_d;
      res_q   <= res_d;
      pos_q   <= pos_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign err             = err_q;
  assign p_addr          = index_q;
  assign bus.ch_ready    = ch_ready_s;
  assign bus.res_valid   = res_valid_s;
  assign bus.res_data    = res_q;
  assign bus.res_pos     = pos_q;
  assign bus.m_read      = m_read_s;
  assign bus.m_write     = m_write_s;
  assign bus.m_addr      = m_addr_s;
  assign bus.m_writedata = m_wdata_s;
  assign unused_rdata_s  = ^bus.m_readdata[31:16];
endmodule

// File: doc/rnn_driver.md
RNN_DRIVER -- requirements
Module: rnn_driver

Interface
REQ-001 Parameter PARAM_WORDS, default 1217, is the number of parameter ROM words loaded per load command (r0 128, r1 1024, rb 32, dense 32, dense bias 1).
REQ-002 Parameter ROM_AW, default 11, is the parameter ROM address width.
REQ-003 Parameter TIMEOUT, default 4096, is the maximum number of poll cycles allowed before an error is raised.
REQ-004 clk  in  1  is the single clock; all logic is on the rising edge.
REQ-005 rst  in  1  is the synchronous, active-high reset.
REQ-006 load_start  in  1  is a one-cycle pulse that requests a parameter load.
REQ-007 busy  out  1  is high whenever the state is not IDLE.
REQ-008 err  out  1  is a sticky poll-timeout flag, cleared by the next accepted load_start or character.
REQ-009 p_addr  out  ROM_AW  is the parameter ROM address; p_data  in  35  is ROM data {tgt_addr[2:0], word[31:0]} with 1-cycle read latency.
REQ-010 ch_valid, ch_ready, ch_last  in/out/in  1 each  form the character stream handshake; ch_data  in  32  carries {emb1[15:0], emb0[15:0]}.
REQ-011 res_valid  out  1, res_ready  in  1, res_data  out  16  (signed Q8.8), res_pos  out  1  form the result handshake.
REQ-012 m_read, m_write  out  1 each, m_addr  out  3, m_writedata  out  32, m_readdata  in  32  form the accelerator register port; read data is valid in the same cycle as m_read.

Function
REQ-013 The block SHALL implement states IDLE, P_RD, P_WR, CH_WAIT, CH_W0, CH_W1, CH_GO, CH_POLL, D_GO, D_POLL, D_RD, RES.
REQ-014 IDLE: load_start goes to P_RD with index 0; otherwise ch_valid goes to CH_WAIT; load_start has priority when both are asserted.
REQ-015 P_RD drives p_addr=index; P_WR issues one m_write with m_addr=p_data[34:32] and m_writedata=p_data[31:0]; after index PARAM_WORDS-1 the state returns to IDLE, otherwise index increments and the state returns to P_RD (2 cycles per word).
REQ-016 ch_ready is high only in CH_WAIT; on ch_valid&&ch_ready the block latches ch_data and ch_last and goes to CH_W0.
REQ-017 CH_W0 writes addr 1 with {8'h00, 8'h00, emb0}; CH_W1 writes addr 1 with {8'h00, 8'h01, emb1}; CH_GO writes addr 0 with data 0.
REQ-018 CH_POLL asserts m_read with m_addr=1 every cycle, starting the cycle after CH_GO; m_readdata[0]==1 exits to D_GO if the latched last flag is set, else to IDLE.
REQ-019 D_GO writes addr 7 (data 0); D_POLL reads addr 0 until m_readdata[0]==1, then goes to D_RD.
REQ-020 D_RD asserts a single m_read at addr 7 (this read also clears the accelerator hidden state), captures res_data=m_readdata[15:0] and res_pos=~m_readdata[15], and goes to RES.
REQ-021 RES holds res_valid high with stable data until res_ready; on handshake the state goes to IDLE.
REQ-022 Each poll state counts cycles; reaching TIMEOUT sets err, deasserts m_read, and goes to IDLE without any further accelerator access.
REQ-023 m_read and m_write SHALL never be asserted together; outside the states listed above both are 0 and m_addr/m_writedata are 0.
REQ-024 load_start and ch_valid are ignored while busy.

Reset
REQ-025 rst SHALL force IDLE, index=0, poll count=0, err=0, and all outputs to 0, including in mid-load or mid-poll; rst does not reset the accelerator.

Structure
REQ-026 A shared package rnn_pkg holds the register map constants (REG_START=0, REG_INPUT=1, REG_R0=2, REG_R1=3, REG_RB=4, REG_DENSE=5, REG_DBIAS=6, REG_RESULT=7) and the driver state typedef.
REQ-027 The block is one module; the poll timeout counter may be a sub-module poll_timer.

Verification
REQ-028 PARAM_WORDS=3, ROM={2,0x0001_0100},{4,0x0003_FF00},{6,0x0000_0080}, load_start -> exactly 3 writes with those addr/data pairs in order, busy high for 6 cycles.
REQ-029 Char 0x0200_0100, ch_last=0, accelerator model returns LOAD after 5 cycles -> writes (1,0x0000_0100), (1,0x0001_0200), (0,0), then 5 reads of addr 1, then IDLE.
REQ-030 Char with ch_last=1, model reports VALID with result 0xFF80 -> write addr 7, poll addr 0, one read of addr 7, res_data=0xFF80, res_pos=0, held until res_ready.
REQ-031 TIMEOUT=8, model never reaches LOAD -> 8 polls, then err=1, IDLE, no further accesses; next char clears err.
REQ-032 rst asserted during P_WR word 2 -> next cycle all outputs 0 and IDLE; a following load_start restarts at p_addr=0.
REQ-033 load_start and ch_valid asserted in the same IDLE cycle -> parameter load runs first and ch_ready stays 0 until it completes.
